// File: rtl/irq_pending_latch.sv
// rtl/irq_pending_latch.sv - synchronised, sticky, maskable interrupt pending latch
module irq_pending_latch #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 1,
    parameter int IDX_W       = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] req_in,
    input  logic             mask_we,
    input  logic [WIDTH-1:0] mask_in,
    input  logic             ack_valid,
    input  logic [IDX_W-1:0] ack_idx,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] pend_out,
    output logic             any_pend,
    output logic [WIDTH-1:0] overflow
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] pend_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] ovf_q;

    logic [WIDTH-1:0] sync_now;
    logic [WIDTH-1:0] set_ev;
    logic [WIDTH-1:0] clr_ev;
    logic [WIDTH-1:0] ovf_set;
    logic [WIDTH-1:0] pend_d;
    logic [WIDTH-1:0] ovf_d;

    assign sync_now = sync_q[SYNC_STAGES-1];

    always_comb begin
        clr_ev = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (ack_valid && (ack_idx == IDX_W'(i))) begin
                clr_ev[i] = 1'b1;
            end
        end
    end

    // A fresh event beats a simultaneous ack, so nothing is lost on that collision.
    always_comb begin
        set_ev  = (EDGE_MODE != 0) ? (sync_now & ~prev_q) : sync_now;
        ovf_set = (EDGE_MODE != 0) ? (set_ev & pend_q & ~clr_ev) : '0;
        pend_d  = set_ev | (pend_q & ~clr_ev);
        ovf_d   = ovf_set | (ovf_clr ? '0 : ovf_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            prev_q <= '0;
            pend_q <= '0;
            mask_q <= '1;
            ovf_q  <= '0;
        end else if (ena) begin
            sync_q[0] <= req_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            prev_q <= sync_now;
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
            if (mask_we) begin
                mask_q <= mask_in;
            end
        end
    end

    assign pend_out = pend_q & mask_q;
    assign any_pend = |(pend_q & mask_q);
    assign overflow = ovf_q;

endmodule

// File: tb/tb_irq_pending_latch.sv
// tb/tb_irq_pending_latch.sv - randomized model-checked bench for irq_pending_latch
module tb_irq_pending_latch;

    localparam int W = 16;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ena;
    logic [W-1:0] req_in;
    logic         mask_we;
    logic [W-1:0] mask_in;
    logic         ack_valid;
    logic [3:0]   ack_idx;
    logic         ovf_clr;
    logic [W-1:0] pend_out;
    logic         any_pend;
    logic [W-1:0] overflow;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    logic [W-1:0] m_pend, m_mask, m_ovf;
    logic [W-1:0] hist[$];

    irq_pending_latch #(.WIDTH(W), .SYNC_STAGES(S), .EDGE_MODE(1), .IDX_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .req_in(req_in),
        .mask_we(mask_we), .mask_in(mask_in), .ack_valid(ack_valid),
        .ack_idx(ack_idx), .ovf_clr(ovf_clr), .pend_out(pend_out),
        .any_pend(any_pend), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = '0;
        m_mask = '1;
        m_ovf  = '0;
        hist.delete();
    endtask

    // hist[k] is the request vector sampled k enabled edges ago; the synchroniser
    // output seen at this edge is the sample from S edges ago, prev one further back.
    task automatic model_edge();
        logic [W-1:0] sy, pv, s, c, o;
        hist.push_front(req_in);
        if (hist.size() > S + 2) void'(hist.pop_back());
        sy = (hist.size() > S)     ? hist[S]     : '0;
        pv = (hist.size() > S + 1) ? hist[S + 1] : '0;
        s  = sy & ~pv;
        c  = ack_valid ? (W'(1) << ack_idx) : '0;
        o  = s & m_pend & ~c;
        m_ovf  = o | (ovf_clr ? '0 : m_ovf);
        m_pend = s | (m_pend & ~c);
        if (mask_we) m_mask = mask_in;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n && ena) model_edge();
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pend_out", 32'(pend_out), 32'(m_pend & m_mask));
            chk("any_pend", 32'(any_pend), 32'(|(m_pend & m_mask)));
            chk("overflow", 32'(overflow), 32'(m_ovf));
        end
    end

    initial begin
        rst_n = 1'b0; ena = 1'b1; req_in = 16'h8001; mask_we = 1'b0; mask_in = '0;
        ack_valid = 1'b0; ack_idx = '0; ovf_clr = 1'b0;
        model_reset();
        chk_en = 1'b1;
        #1;
        chk("rst_pend", 32'(pend_out), 32'h0);
        chk("rst_any", 32'(any_pend), 32'h0);
        chk("rst_ovf", 32'(overflow), 32'h0);
        step(); step();
        rst_n = 1'b1;

        step(); chk("lat1", 32'(pend_out), 32'h0);
        step(); chk("lat2", 32'(pend_out), 32'h0);
        step(); chk("lat3", 32'(pend_out), 32'h8001);
        chk("lat3_any", 32'(any_pend), 32'h1);
        repeat (3) step();
        chk("hold_no_reset", 32'(pend_out), 32'h8001);

        ack_valid = 1'b1; ack_idx = 4'd15; step();
        chk("ack15", 32'(pend_out), 32'h0001);
        ack_idx = 4'd0; step(); ack_valid = 1'b0;
        chk("ack0", 32'(pend_out), 32'h0000);
        chk("ack0_any", 32'(any_pend), 32'h0);

        req_in[5] = 1'b1; repeat (3) step();
        chk("bit5_set", 32'(pend_out), 32'h0020);
        req_in[5] = 1'b0; repeat (2) step();
        req_in[5] = 1'b1; repeat (3) step();
        chk("bit5_hold", 32'(pend_out), 32'h0020);
        chk("bit5_ovf", 32'(overflow), 32'h0020);
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        chk("ovf_clr", 32'(overflow), 32'h0);

        req_in[3] = 1'b1; repeat (3) step();
        req_in[3] = 1'b0; repeat (2) step();
        req_in[3] = 1'b1; step(); step();
        ack_valid = 1'b1; ack_idx = 4'd3; step(); ack_valid = 1'b0;
        chk("bit3_collide", 32'(pend_out), 32'h0028);
        chk("bit3_no_ovf", 32'(overflow), 32'h0);
        ack_valid = 1'b1; ack_idx = 4'd3; step();
        ack_idx = 4'd5; step(); ack_valid = 1'b0;
        chk("cleared", 32'(pend_out), 32'h0);

        req_in = '0; repeat (3) step();
        req_in = 16'h0101; repeat (3) step();
        chk("p0101", 32'(pend_out), 32'h0101);
        mask_we = 1'b1; mask_in = 16'hFF00; step(); mask_we = 1'b0;
        chk("masked", 32'(pend_out), 32'h0100);
        ack_valid = 1'b1; ack_idx = 4'd8; step(); ack_valid = 1'b0;
        chk("ack8", 32'(pend_out), 32'h0);
        chk("ack8_any", 32'(any_pend), 32'h0);
        mask_we = 1'b1; mask_in = 16'hFFFF; step(); mask_we = 1'b0;
        chk("unmask", 32'(pend_out), 32'h0001);

        ena = 1'b0;
        for (int i = 0; i < 6; i++) begin
            req_in = W'($urandom);
            ack_valid = 1'b1; ack_idx = 4'd0; mask_we = 1'b1; mask_in = '0;
            step();
        end
        ack_valid = 1'b0; mask_we = 1'b0;
        chk("freeze_pend", 32'(pend_out), 32'h0001);
        chk("freeze_ovf", 32'(overflow), 32'h0);
        ena = 1'b1; repeat (4) step();
        mask_we = 1'b1; mask_in = '0; step(); mask_we = 1'b0;

        #2; rst_n = 1'b0; model_reset(); req_in = '0; #1;
        chk("async_pend", 32'(pend_out), 32'h0);
        chk("async_any", 32'(any_pend), 32'h0);
        chk("async_ovf", 32'(overflow), 32'h0);
        step(); rst_n = 1'b1;
        req_in = 16'h0100; repeat (3) step();
        chk("mask_reset_ones", 32'(pend_out), 32'h0100);

        for (int i = 0; i < 1500; i++) begin
            for (int b = 0; b < W; b++) begin
                if ($urandom_range(0, 5) == 0) req_in[b] = ~req_in[b];
            end
            ack_valid = ($urandom_range(0, 9) < 3);
            ack_idx   = 4'($urandom_range(0, 15));
            mask_we   = ($urandom_range(0, 19) == 0);
            mask_in   = W'($urandom);
            ovf_clr   = ($urandom_range(0, 19) == 0);
            ena       = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 99) == 0) begin
                #2; rst_n = 1'b0; model_reset(); #1;
                chk("rnd_async_pend", 32'(pend_out), 32'h0);
                chk("rnd_async_ovf", 32'(overflow), 32'h0);
                step();
                rst_n = 1'b1;
            end else begin
                step();
            end
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/irq_pending_latch.md
# irq_pending_latch

Request-capture stage that sits directly upstream of the 16-input priority encoder. It synchronises up to 16 asynchronous request lines and detects their rising edges (or levels). It holds each event as a sticky pending bit until the consumer acknowledges it by index, then presents the masked pending vector for encoding. It also flags events lost because their bit was already pending.

## Interface
Parameters:
- WIDTH, 16, number of request lines (2..16)
- SYNC_STAGES, 2, flip-flops per synchroniser (>=2)
- EDGE_MODE, 1, 1 = rising-edge capture, 0 = level capture
- IDX_W, 4, width of ack index ($clog2(WIDTH), minimum 1)

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low; one clock, asynchronous active-low reset
- ena  in  1  global enable; 0 = every register holds
- req_in  in  WIDTH  raw asynchronous requests
- mask_we  in  1  load mask_in into mask register
- mask_in  in  WIDTH  new mask (1 = bit visible)
- ack_valid  in  1  acknowledge strobe, one cycle per ack
- ack_idx  in  IDX_W  index of pending bit to clear (encoder output)
- ovf_clr  in  1  clear overflow register
- pend_out  out  WIDTH  pending & mask, registered-state driven, feeds encoder
- any_pend  out  1  |pend_out
- overflow  out  WIDTH  sticky lost-event flags

## Operation
- Each req_in[i] passes through a SYNC_STAGES flop chain to sync[i]. A history flop prev[i] holds sync[i] from the previous cycle.
- Set event: EDGE_MODE=1, set[i] = sync[i] & ~prev[i]. EDGE_MODE=0, set[i] = sync[i].
- Clear event: clr[i] = ack_valid & (ack_idx == i). ack_idx >= WIDTH is ignored.
- Pending update per bit: next = set | (pend & ~clr). Set and clear of the same bit in the same cycle leaves the bit set, so no new event is lost.
- Overflow: in EDGE_MODE=1, ovf[i] is set when set[i] & pend[i] & ~clr[i]. In EDGE_MODE=0, overflow is never set.
- ovf_clr zeroes overflow, but an overflow set in the same cycle wins.
- Mask register:
  - Loaded with mask_in when mask_we=1.
  - Masking hides a bit only. Pending still latches and ack still clears a masked bit.
  - Unmasking exposes any held pending bit on the next cycle.
- Level mode: an acked bit whose sync level is still high re-sets on the next cycle.
- ena=0 freezes the sync chain, prev, pending, mask and overflow. All inputs are ignored. Outputs hold.
- No FSM beyond the per-bit set/clear logic. Target 120-400 lines including parameter checks.

## Timing
- Reset values:
  - sync chain 0, prev 0, pending 0, overflow 0
  - mask all ones
  - pend_out 0, any_pend 0
- Reset asserted mid-operation clears all state immediately (asynchronously), regardless of ena.
- Latency from req_in rising, with setup before clock edge N:
  - sync[i] high after edge N+SYNC_STAGES-1.
  - pending high after edge N+SYNC_STAGES.
  - Total is SYNC_STAGES+1 edges; default 3.
- Request high through reset release: prev resets to 0, so EDGE_MODE=1 captures one edge SYNC_STAGES+1 cycles after release.
- Ack latency: ack_valid sampled at edge M clears the bit. pend_out drops after edge M. any_pend updates in the same cycle.
- mask_we sampled at edge M: pend_out reflects the new mask after edge M.
- pend_out and any_pend depend only on registers. There is no combinational path from inputs to outputs.
- Minimum request pulse width for guaranteed capture is 2 clk periods. Shorter pulses may be missed and this is not flagged.

## Test plan
- Reset, then req_in=16'h8001 held high (EDGE_MODE=1, SYNC_STAGES=2) -> pend_out=16'h0000 for 2 cycles, 16'h8001 after 3rd edge, any_pend=1. No re-set while the level is held.
- ack_valid=1, ack_idx=15 for one cycle -> pend_out=16'h0001. Then ack_idx=0 -> pend_out=0, any_pend=0.
- Bit 5 pending; drop req_in[5], re-raise it, no ack -> pending stays 16'h0020 and overflow=16'h0020. ovf_clr -> overflow=0.
- Bit 3 edge arrives in the same cycle as ack_idx=3 -> bit 3 remains pending and overflow[3] stays 0.
- mask_we with mask_in=16'hFF00 while pending=16'h0101 -> pend_out=16'h0100. Ack 8 -> pend_out=0 with internal bit 0 still pending. Then mask_in=16'hFFFF -> pend_out=16'h0001.
- ena=0 while req_in toggles, then ena=1 -> no pending change during freeze. Drive rst_n low mid-stream -> all outputs 0 immediately and mask reads back all ones (pend_out shows pending bits unfiltered).
